// File: rtl/u712_bus_sizer.sv
// Splits one CPU transfer (byte/word/long/line) into port-width beats with a
// PREQ/PACK handshake per beat, registered lane enables and a DONE/ERR pulse.
module u712_bus_sizer #(
    parameter int PORT_BYTES = 2,
    parameter bit LINE_EN    = 1'b1
) (
    input  logic                  CLK40,
    input  logic                  RESETn,
    input  logic                  START,
    input  logic [3:0]            A,
    input  logic [1:0]            SIZ,
    input  logic                  RnW,
    input  logic                  PACK,
    output logic                  BUSY,
    output logic                  PREQ,
    output logic [3:0]            PA,
    output logic [0:PORT_BYTES-1] PBEn,
    output logic [3:0]            CBEn,
    output logic                  PRnW,
    output logic                  DONE,
    output logic                  ERR
);

    generate
        if (!(PORT_BYTES == 1 || PORT_BYTES == 2 || PORT_BYTES == 4)) begin : g_bad_width
            $error("u712_bus_sizer: PORT_BYTES must be 1, 2 or 4");
        end
    endgenerate

    typedef logic [0:PORT_BYTES-1] pben_t;
    typedef enum logic [1:0] {IDLE, BEAT, FINISH} state_t;

    localparam logic [2:0] PB3      = 3'(PORT_BYTES);
    localparam logic [1:0] OFF_MASK = 2'(PORT_BYTES - 1);
    localparam pben_t      PBEN_OFF = '1;

    // Bytes in the beat at pa: limited by what is left and by the port lane room.
    function automatic logic [2:0] beat_bytes(input logic [3:0] pa, input logic [4:0] rem);
        logic [2:0] room;
        room = PB3 - {1'b0, pa[1:0] & OFF_MASK};
        return (rem < {2'b00, room}) ? rem[2:0] : room;
    endfunction

    function automatic pben_t pben_of(input logic [3:0] pa, input logic [2:0] beat);
        pben_t v;
        int    off;
        off = int'(pa[1:0] & OFF_MASK);
        for (int l = 0; l < PORT_BYTES; l++) begin
            v[l] = !((l >= off) && (l < off + int'(beat)));
        end
        return v;
    endfunction

    // CBEn bit 3 carries address offset 0 within the longword.
    function automatic logic [3:0] cben_of(input logic [3:0] pa, input logic [2:0] beat);
        logic [3:0] v;
        int         off;
        off = int'(pa[1:0]);
        for (int b = 0; b < 4; b++) begin
            v[b] = !(((3 - b) >= off) && ((3 - b) < off + int'(beat)));
        end
        return v;
    endfunction

    state_t     state_q;
    logic [3:0] pa_q;
    logic [4:0] rem_q;
    logic [2:0] beat_q;
    logic       clip_q;
    logic       busy_q, preq_q, prnw_q, done_q, err_q;
    pben_t      pben_q;
    logic [3:0] cben_q;

    logic       cap_line_d, cap_clip_d;
    logic [3:0] cap_pa_d;
    logic [4:0] cap_n_d, cap_raw_d, cap_span_d;
    logic [2:0] cap_beat_d;
    logic [4:0] adv_rem_d;
    logic [3:0] adv_pa_d;
    logic [2:0] adv_beat_d;

    always_comb begin
        cap_line_d = (SIZ == 2'b11) && LINE_EN;
        cap_pa_d   = cap_line_d ? {A[3:2], 2'b00} : A;
        case (SIZ)
            2'b01:   cap_raw_d = 5'd1;
            2'b10:   cap_raw_d = 5'd2;
            2'b11:   cap_raw_d = cap_line_d ? 5'd16 : 5'd4;
            default: cap_raw_d = 5'd4;
        endcase
        // Non-line requests are clipped at the longword boundary.
        cap_span_d = {3'b000, A[1:0]} + cap_raw_d;
        cap_clip_d = !cap_line_d && (cap_span_d > 5'd4);
        cap_n_d    = cap_clip_d ? (5'd4 - {3'b000, A[1:0]}) : cap_raw_d;
        cap_beat_d = beat_bytes(cap_pa_d, cap_n_d);

        // 4-bit address addition gives the modulo-16 line wrap for free.
        adv_rem_d  = rem_q - {2'b00, beat_q};
        adv_pa_d   = pa_q + {1'b0, beat_q};
        adv_beat_d = beat_bytes(adv_pa_d, adv_rem_d);
    end

    always_ff @(posedge CLK40) begin
        if (!RESETn) begin
            state_q <= IDLE;
            pa_q    <= 4'h0;
            rem_q   <= 5'd0;
            beat_q  <= 3'd0;
            clip_q  <= 1'b0;
            busy_q  <= 1'b0;
            preq_q  <= 1'b0;
            prnw_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pben_q  <= PBEN_OFF;
            cben_q  <= 4'hF;
        end else begin
            case (state_q)
                BEAT: begin
                    if (PACK) begin
                        if (adv_rem_d == 5'd0) begin
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            preq_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= clip_q;
                            pben_q  <= PBEN_OFF;
                            cben_q  <= 4'hF;
                            rem_q   <= 5'd0;
                        end else begin
                            pa_q   <= adv_pa_d;
                            rem_q  <= adv_rem_d;
                            beat_q <= adv_beat_d;
                            pben_q <= pben_of(adv_pa_d, adv_beat_d);
                            cben_q <= cben_of(adv_pa_d, adv_beat_d);
                        end
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (START) begin
                        state_q <= BEAT;
                        pa_q    <= cap_pa_d;
                        rem_q   <= cap_n_d;
                        beat_q  <= cap_beat_d;
                        clip_q  <= cap_clip_d;
                        busy_q  <= 1'b1;
                        preq_q  <= 1'b1;
                        prnw_q  <= RnW;
                        pben_q  <= pben_of(cap_pa_d, cap_beat_d);
                        cben_q  <= cben_of(cap_pa_d, cap_beat_d);
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign PREQ = preq_q;
    assign PA   = pa_q;
    assign PBEn = pben_q;
    assign CBEn = cben_q;
    assign PRnW = prnw_q;
    assign DONE = done_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_u712_bus_sizer.sv
// Directed bench for u712_bus_sizer: three instances with 1-, 2- and 4-byte ports.
module tb_u712_bus_sizer;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic       start1, rnw1, pack1, busy1, preq1, prnw1, done1, err1;
    logic [3:0] a1, pa1, cben1;
    logic [1:0] siz1;
    logic [0:0] pben1;

    logic       start2, rnw2, pack2, busy2, preq2, prnw2, done2, err2;
    logic [3:0] a2, pa2, cben2;
    logic [1:0] siz2;
    logic [0:1] pben2;

    logic       start4, rnw4, pack4, busy4, preq4, prnw4, done4, err4;
    logic [3:0] a4, pa4, cben4;
    logic [1:0] siz4;
    logic [0:3] pben4;

    int total = 0;
    int bad   = 0;

    u712_bus_sizer #(.PORT_BYTES(1), .LINE_EN(1'b1)) dut1 (
        .CLK40(clk), .RESETn(rstn), .START(start1), .A(a1), .SIZ(siz1), .RnW(rnw1),
        .PACK(pack1), .BUSY(busy1), .PREQ(preq1), .PA(pa1), .PBEn(pben1), .CBEn(cben1),
        .PRnW(prnw1), .DONE(done1), .ERR(err1));

    u712_bus_sizer #(.PORT_BYTES(2), .LINE_EN(1'b1)) dut2 (
        .CLK40(clk), .RESETn(rstn), .START(start2), .A(a2), .SIZ(siz2), .RnW(rnw2),
        .PACK(pack2), .BUSY(busy2), .PREQ(preq2), .PA(pa2), .PBEn(pben2), .CBEn(cben2),
        .PRnW(prnw2), .DONE(done2), .ERR(err2));

    u712_bus_sizer #(.PORT_BYTES(4), .LINE_EN(1'b1)) dut4 (
        .CLK40(clk), .RESETn(rstn), .START(start4), .A(a4), .SIZ(siz4), .RnW(rnw4),
        .PACK(pack4), .BUSY(busy4), .PREQ(preq4), .PA(pa4), .PBEn(pben4), .CBEn(cben4),
        .PRnW(prnw4), .DONE(done4), .ERR(err4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected PBEn values are written with bit index 0 as the leftmost digit.
    task automatic st1(input string tag, input logic busy, input logic preq, input logic [3:0] pa,
                       input logic pben, input logic [3:0] cben, input logic done, input logic err);
        chk({tag, ".busy"}, {31'b0, busy1}, {31'b0, busy});
        chk({tag, ".preq"}, {31'b0, preq1}, {31'b0, preq});
        chk({tag, ".pa"},   {28'b0, pa1},   {28'b0, pa});
        chk({tag, ".pben"}, {31'b0, pben1}, {31'b0, pben});
        chk({tag, ".cben"}, {28'b0, cben1}, {28'b0, cben});
        chk({tag, ".done"}, {31'b0, done1}, {31'b0, done});
        chk({tag, ".err"},  {31'b0, err1},  {31'b0, err});
    endtask

    task automatic st2(input string tag, input logic busy, input logic preq, input logic [3:0] pa,
                       input logic [1:0] pben, input logic [3:0] cben, input logic done, input logic err);
        chk({tag, ".busy"}, {31'b0, busy2}, {31'b0, busy});
        chk({tag, ".preq"}, {31'b0, preq2}, {31'b0, preq});
        chk({tag, ".pa"},   {28'b0, pa2},   {28'b0, pa});
        chk({tag, ".pben"}, {30'b0, pben2}, {30'b0, pben});
        chk({tag, ".cben"}, {28'b0, cben2}, {28'b0, cben});
        chk({tag, ".done"}, {31'b0, done2}, {31'b0, done});
        chk({tag, ".err"},  {31'b0, err2},  {31'b0, err});
    endtask

    task automatic st4(input string tag, input logic busy, input logic preq, input logic [3:0] pa,
                       input logic [3:0] pben, input logic [3:0] cben, input logic done, input logic err);
        chk({tag, ".busy"}, {31'b0, busy4}, {31'b0, busy});
        chk({tag, ".preq"}, {31'b0, preq4}, {31'b0, preq});
        chk({tag, ".pa"},   {28'b0, pa4},   {28'b0, pa});
        chk({tag, ".pben"}, {28'b0, pben4}, {28'b0, pben});
        chk({tag, ".cben"}, {28'b0, cben4}, {28'b0, cben});
        chk({tag, ".done"}, {31'b0, done4}, {31'b0, done});
        chk({tag, ".err"},  {31'b0, err4},  {31'b0, err});
    endtask

    initial begin
        rstn = 1'b0;
        start1 = 0; a1 = 0; siz1 = 0; rnw1 = 1; pack1 = 0;
        start2 = 0; a2 = 0; siz2 = 0; rnw2 = 1; pack2 = 0;
        start4 = 0; a4 = 0; siz4 = 0; rnw4 = 1; pack4 = 0;
        tick();
        tick();
        st1("rst1", 0, 0, 4'h0, 1'b1, 4'hF, 0, 0);
        st2("rst2", 0, 0, 4'h0, 2'b11, 4'hF, 0, 0);
        st4("rst4", 0, 0, 4'h0, 4'hF, 4'hF, 0, 0);
        chk("rst.prnw", {31'b0, prnw2}, 32'd1);
        rstn = 1'b1;
        tick();

        // PB=2 long at A=0, PACK held high
        start2 = 1; a2 = 4'h0; siz2 = 2'b00; rnw2 = 1; pack2 = 1;
        tick();
        start2 = 0;
        st2("t1.b0", 1, 1, 4'h0, 2'b00, 4'b0011, 0, 0);
        tick();
        st2("t1.b1", 1, 1, 4'h2, 2'b00, 4'b1100, 0, 0);
        tick();
        st2("t1.done", 0, 0, 4'h2, 2'b11, 4'hF, 1, 0);
        pack2 = 0;
        tick();
        st2("t1.idle", 0, 0, 4'h2, 2'b11, 4'hF, 0, 0);

        // PB=1 word at A=2, slow PACK
        start1 = 1; a1 = 4'h2; siz1 = 2'b10; rnw1 = 0; pack1 = 0;
        tick();
        start1 = 0; a1 = 4'hF; siz1 = 2'b11;
        st1("t2.b0", 1, 1, 4'h2, 1'b0, 4'b1101, 0, 0);
        chk("t2.prnw", {31'b0, prnw1}, 32'd0);
        tick();
        st1("t2.hold0a", 1, 1, 4'h2, 1'b0, 4'b1101, 0, 0);
        tick();
        st1("t2.hold0b", 1, 1, 4'h2, 1'b0, 4'b1101, 0, 0);
        pack1 = 1;
        tick();
        pack1 = 0;
        st1("t2.b1", 1, 1, 4'h3, 1'b0, 4'b1110, 0, 0);
        tick();
        st1("t2.hold1a", 1, 1, 4'h3, 1'b0, 4'b1110, 0, 0);
        tick();
        st1("t2.hold1b", 1, 1, 4'h3, 1'b0, 4'b1110, 0, 0);
        pack1 = 1;
        tick();
        pack1 = 0;
        st1("t2.done", 0, 0, 4'h3, 1'b1, 4'hF, 1, 0);

        // PB=4 line at A=A, starts at 8 and wraps
        start4 = 1; a4 = 4'hA; siz4 = 2'b11; rnw4 = 1; pack4 = 1;
        tick();
        start4 = 0;
        st4("t3.b0", 1, 1, 4'h8, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t3.b1", 1, 1, 4'hC, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t3.b2", 1, 1, 4'h0, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t3.b3", 1, 1, 4'h4, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t3.done", 0, 0, 4'h4, 4'hF, 4'hF, 1, 0);
        pack4 = 0;
        tick();

        // PB=2 word at A=3 clipped to one byte
        start2 = 1; a2 = 4'h3; siz2 = 2'b10; rnw2 = 1; pack2 = 1;
        tick();
        start2 = 0;
        st2("t4.b0", 1, 1, 4'h3, 2'b10, 4'b1110, 0, 0);
        tick();
        st2("t4.done", 0, 0, 4'h3, 2'b11, 4'hF, 1, 1);
        pack2 = 0;
        tick();
        st2("t4.idle", 0, 0, 4'h3, 2'b11, 4'hF, 0, 0);

        // PB=4 long at A=1 clipped to three bytes
        start4 = 1; a4 = 4'h1; siz4 = 2'b00; pack4 = 1;
        tick();
        start4 = 0;
        st4("t4b.b0", 1, 1, 4'h1, 4'b1000, 4'b1000, 0, 0);
        tick();
        st4("t4b.done", 0, 0, 4'h1, 4'hF, 4'hF, 1, 1);
        pack4 = 0;
        tick();

        // PB=4 line reset after 2nd PACK with START high
        start4 = 1; a4 = 4'h0; siz4 = 2'b11; rnw4 = 0; pack4 = 1;
        tick();
        start4 = 0;
        st4("t5.b0", 1, 1, 4'h0, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t5.b1", 1, 1, 4'h4, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t5.b2", 1, 1, 4'h8, 4'h0, 4'h0, 0, 0);
        rstn = 0; start4 = 1; a4 = 4'h4; siz4 = 2'b00; rnw4 = 1;
        tick();
        st4("t5.rst", 0, 0, 4'h0, 4'hF, 4'hF, 0, 0);
        chk("t5.rst.prnw", {31'b0, prnw4}, 32'd1);
        rstn = 1;
        tick();
        start4 = 0;
        st4("t5.new", 1, 1, 4'h4, 4'h0, 4'h0, 0, 0);
        tick();
        st4("t5.done", 0, 0, 4'h4, 4'hF, 4'hF, 1, 0);
        pack4 = 0;
        tick();

        // PB=2 back-to-back: byte at A=1, then word at A=6 from the DONE cycle
        start2 = 1; a2 = 4'h1; siz2 = 2'b01; rnw2 = 1; pack2 = 0;
        tick();
        st2("t6.b0", 1, 1, 4'h1, 2'b10, 4'b1011, 0, 0);
        a2 = 4'hC; siz2 = 2'b00;
        tick();
        st2("t6.ign", 1, 1, 4'h1, 2'b10, 4'b1011, 0, 0);
        pack2 = 1;
        tick();
        st2("t6.done", 0, 0, 4'h1, 2'b11, 4'hF, 1, 0);
        a2 = 4'h6; siz2 = 2'b10; rnw2 = 0; pack2 = 0;
        tick();
        start2 = 0;
        st2("t6.b2b", 1, 1, 4'h6, 2'b00, 4'b1100, 0, 0);
        chk("t6.prnw", {31'b0, prnw2}, 32'd0);
        start2 = 1; a2 = 4'h0; siz2 = 2'b11;
        tick();
        start2 = 0;
        st2("t6.hold", 1, 1, 4'h6, 2'b00, 4'b1100, 0, 0);
        pack2 = 1;
        tick();
        pack2 = 0;
        st2("t6.done2", 0, 0, 4'h6, 2'b11, 4'hF, 1, 0);
        tick();
        st2("t6.idle0", 0, 0, 4'h6, 2'b11, 4'hF, 0, 0);
        tick();
        st2("t6.idle1", 0, 0, 4'h6, 2'b11, 4'hF, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
